div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_if.sv | 29 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 35;
  localparam int DIV_CNT_W   = 5;

  // Counter starts here so that RUN lasts exactly DIV_WIDTH cycles.
  localparam logic [DIV_CNT_W-1:0] DIV_ITER_LAST = DIV_CNT_W'(DIV_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } div_state_t;

  // Absolute value of a two's-complement operand when en is set,
  // raw value otherwise.
  function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 en);
    return (en && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between a requester and div_unit.
// Latency: n/a (wires only).
// Backpressure: busy high means start is ignored; no queueing.
// Ports: start/is_signed/dividend/divisor (request), busy/done/quotient/
//        remainder/div_by_zero (response).
interface div_if;
  import div_pkg::*;

  logic                 start;
  logic                 is_signed;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift, compare, conditional subtract.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i/quo_i partial remainder and dividend/quotient shift register,
//        dvs_i divisor magnitude; rem_o/quo_o values after the step.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);

  // 33-bit partial remainder after shifting in the next dividend bit.
  logic [DIV_WIDTH:0] shifted;
  logic               ge;

  assign shifted = {rem_i, quo_i[DIV_WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_i};

  // When ge is set the true difference is below dvs_i, so a 32-bit
  // subtraction of the low bits yields it exactly.
  assign rem_o = ge ? (shifted[DIV_WIDTH-1:0] - dvs_i) : shifted[DIV_WIDTH-1:0];
  assign quo_o = {quo_i[DIV_WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned restoring divider (DIV/DIVU), one quotient bit per cycle.
// Latency: 35 cycles from the start-sampling edge; done is a one-cycle pulse.
// Backpressure: start is ignored while busy (including the done cycle); no queueing.
// Ports: clk, reset (async active-low), bus (div_if.slave request/response).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  div_if.slave     bus
);

  div_state_t           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;       // raw latched dividend
  logic [WIDTH-1:0]     b_q, b_d;       // raw latched divisor
  logic                 sgn_q, sgn_d;   // latched is_signed
  logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]     quo_q, quo_d;   // dividend bits shifting out, quotient bits in
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [WIDTH-1:0]     q_res_q, q_res_d;
  logic [WIDTH-1:0]     r_res_q, r_res_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     step_rem, step_quo;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          sgn_d   = bus.is_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        dvs_d   = div_mag(b_q, sgn_q);
        quo_d   = div_mag(a_q, sgn_q);
        q_neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        r_neg_d = a_q[WIDTH-1];
        rem_d   = '0;
        cnt_d   = DIV_ITER_LAST;
        state_d = RUN;
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        // Result registers load here so they change exactly on DONE entry.
        if (b_q == '0) begin
          q_res_d = '1;
          r_res_d = a_q;
          dbz_d   = 1'b1;
        end else begin
          q_res_d = (sgn_q && q_neg_q) ? -quo_q : quo_q;
          r_res_d = (sgn_q && r_neg_q) ? -rem_q : rem_q;
          dbz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_res_q <= '0;
      r_res_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = q_res_q;
  assign bus.remainder   = r_res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized
// operands against an arithmetic reference model, and mid-operation reset.
module tb_div_unit;
  import div_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  div_if bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic from the architectural rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Issue one operation, scramble inputs while busy, poke start mid-run and
  // in the done cycle, then check latency, results and return to idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez);
    int n;
    int busy_bad;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    n        = 1;
    busy_bad = 0;
    while (bus.done !== 1'b1 && n < 80) begin
      if (bus.busy !== 1'b1) busy_bad++;
      bus.start     = (n == 5);
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(DIV_LATENCY));
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold_q"}, bus.quotient, eq);
    chk({tag, "_hold_r"}, bus.remainder, er);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        s, ez;
    int          n;
    int          seen;

    checks        = 0;
    failures      = 0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    reset         = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("divu_100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
    run_op("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_op("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
    run_op("div_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
    run_op("divu_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);
    run_op("divu_zero",    32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
    run_op("div_zero_neg", 32'h8000_0005,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0005,  1'b1);
    run_op("div_m9_m4",    32'hFFFF_FFF7,  32'hFFFF_FFFC,  1'b1, 32'd2,          32'hFFFF_FFFF,  1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0;
        3:       b = -32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, eq, er, ez);
      run_op("rand", a, b, s, eq, er, ez);
    end

    run_op("pre_rst", 32'd5, 32'd2, 1'b0, 32'd2, 32'd1, 1'b0);

    // Abort a running 100/7 with reset; a start pulse mid-run must not queue.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(posedge clk);
    #1;
    n = 1;
    while (n < 10) begin
      bus.start = (n == 5);
      if (n == 5) begin
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_q", bus.quotient, 32'd0);
    chk("abort_r", bus.remainder, 32'd0);
    chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    run_op("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
